digit_serial_addsub: RTL and testbench

- Parametrised, multi-cycle successor to the team's combinational N-bit subtractor.
- Computes A-B or A+B over N/D cycles, D bits (one digit) per clock, with a registered carry/borrow.
- Start/busy/done handshake; result is N+1 bits plus a signed-overflow flag.
- Intended as an area-lean arithmetic unit inside sequencer/datapath blocks where throughput is not critical.

---
 rtl/addsub_pkg.sv | 14 +
 rtl/digit_addsub.sv | 23 ++
 rtl/digit_serial_addsub.sv | 135 +++++++++++++
 tb/tb_digit_serial_addsub.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared types for the digit-serial add/subtract unit.
// FSM states and mode encodings.
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_SUB = 1'b0;
  localparam logic MODE_ADD = 1'b1;

endpackage

// File: rtl/digit_addsub.sv
// One-digit combinational adder slice.
// Operand inversion for subtract is handled by the caller.
module digit_addsub #(
  parameter int D = 2
) (
  input  logic [D-1:0] a,
  input  logic [D-1:0] b,
  input  logic         cin,
  output logic [D-1:0] sum,
  output logic         cout
);

  logic [D:0] w_tot;

  // Full-width digit sum including incoming carry
  always_comb begin
    w_tot = {1'b0, a} + {1'b0, b} + {{D{1'b0}}, cin};
  end

  assign sum  = w_tot[D-1:0];
  assign cout = w_tot[D];

endmodule

// File: rtl/digit_serial_addsub.sv
// Digit-serial A+B / A-B over N/D cycles with a registered carry.
// Result and overflow are published once, when the last digit retires.
module digit_serial_addsub #(
  parameter int N = 8,
  parameter int D = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         mode,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         busy,
  output logic         done,
  output logic [N:0]   S,
  output logic         ovf
);

  import addsub_pkg::*;

  localparam int NDIG = N / D;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  state_t         r_state;
  state_t         w_next;
  logic [N-1:0]   r_a_sh;
  logic [N-1:0]   r_b_sh;
  logic [N-1:0]   r_acc;
  logic           r_mode;
  logic           r_carry;
  logic           r_a_msb;
  logic           r_b_msb;
  logic [CW-1:0]  r_cnt;
  logic [N:0]     r_s;
  logic           r_ovf;

  logic [D-1:0]   w_bd;
  logic [D-1:0]   w_sum;
  logic           w_cout;
  logic [N-1:0]   w_acc_nx;
  logic           w_last;
  logic           w_accept;
  logic           w_s_msb;
  logic           w_ovf;

  assign w_bd = (r_mode == MODE_ADD) ? r_b_sh[D-1:0]
                                     : ~r_b_sh[D-1:0];

  digit_addsub #(.D(D)) u_dig (
    .a    (r_a_sh[D-1:0]),
    .b    (w_bd),
    .cin  (r_carry),
    .sum  (w_sum),
    .cout (w_cout)
  );

  generate
    if (NDIG == 1) begin : g_one
      assign w_acc_nx = w_sum;
    end else begin : g_multi
      assign w_acc_nx = {w_sum, r_acc[N-1:D]};
    end
  endgenerate

  assign w_last   = (r_cnt == CW'(NDIG - 1));
  assign w_accept = start &&
                    ((r_state == IDLE) || (r_state == DONE));
  assign w_s_msb  = (r_mode == MODE_ADD) ? w_cout : ~w_cout;

  // Overflow: operand signs agree (add) or differ (sub) and result sign flips
  always_comb begin
    w_ovf = 1'b0;
    if (r_mode == MODE_ADD)
      w_ovf = (r_a_msb == r_b_msb) && (w_acc_nx[N-1] != r_a_msb);
    else
      w_ovf = (r_a_msb != r_b_msb) && (w_acc_nx[N-1] != r_a_msb);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (start) w_next = RUN;
      RUN:     if (w_last) w_next = DONE;
      DONE:    w_next = start ? RUN : IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Operand shifting, digit accumulation and result publication
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_acc   <= '0;
      r_mode  <= 1'b0;
      r_carry <= 1'b0;
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_cnt   <= '0;
      r_s     <= '0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a_sh  <= A;
      r_b_sh  <= B;
      r_mode  <= mode;
      r_carry <= ~mode;
      r_a_msb <= A[N-1];
      r_b_msb <= B[N-1];
      r_cnt   <= '0;
    end else if (r_state == RUN) begin
      r_a_sh  <= r_a_sh >> D;
      r_b_sh  <= r_b_sh >> D;
      r_acc   <= w_acc_nx;
      r_carry <= w_cout;
      r_cnt   <= r_cnt + 1'b1;
      if (w_last) begin
        r_s   <= {w_s_msb, w_acc_nx};
        r_ovf <= w_ovf;
      end
    end
  end

  assign busy = (r_state == RUN);
  assign done = (r_state == DONE);
  assign S    = r_s;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_digit_serial_addsub.sv
// Bench for digit_serial_addsub (N=8, D=2).
// Arithmetic/timing model plus directed literal checks.
module tb_digit_serial_addsub;

  localparam int N    = 8;
  localparam int D    = 2;
  localparam int NDIG = N / D;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         mode;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         busy;
  logic         done;
  logic [N:0]   S;
  logic         ovf;

  int total = 0;
  int bad   = 0;

  digit_serial_addsub #(.N(N), .D(D)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .mode  (mode),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .S     (S),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [N:0] ref_s(input logic [N-1:0] a,
                                       input logic [N-1:0] b,
                                       input logic m);
    logic [N:0] za;
    logic [N:0] zb;
    za = {1'b0, a};
    zb = {1'b0, b};
    return m ? (za + zb) : (za - zb);
  endfunction

  function automatic logic ref_o(input logic [N-1:0] a,
                                 input logic [N-1:0] b,
                                 input logic m);
    int sa;
    int sb;
    int r;
    sa = $signed(a);
    sb = $signed(b);
    r  = m ? (sa + sb) : (sa - sb);
    return (r > (2 ** (N - 1)) - 1) || (r < -(2 ** (N - 1)));
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Model: cycles left in an operation, pending and published result
  int         m_left;
  logic       m_done;
  logic [N:0] m_s;
  logic       m_ovf;
  logic [N:0] p_s;
  logic       p_ovf;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left <= 0;
      m_done <= 1'b0;
      m_s    <= '0;
      m_ovf  <= 1'b0;
      p_s    <= '0;
      p_ovf  <= 1'b0;
    end else begin
      m_done <= (m_left == 1);
      if (m_left == 1) begin
        m_s   <= p_s;
        m_ovf <= p_ovf;
      end
      if (m_left != 0) begin
        m_left <= m_left - 1;
      end else if (start) begin
        m_left <= NDIG;
        p_s    <= ref_s(A, B, mode);
        p_ovf  <= ref_o(A, B, mode);
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (!rst) begin
      chk("busy", 32'(busy), 32'(m_left != 0));
      chk("done", 32'(done), 32'(m_done));
      chk("S", 32'(S), 32'(m_s));
      chk("ovf", 32'(ovf), 32'(m_ovf));
    end
  end

  task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic m);
    @(posedge clk); #1;
    A = a; B = b; mode = m; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int n, output int nb);
    n  = 1;
    nb = 0;
    for (int i = 0; i < 30; i++) begin
      if (done) break;
      if (busy) nb++;
      @(posedge clk); #1;
      n++;
    end
    if (!done) chk("timeout", 32'(done), 32'd1);
  endtask

  task automatic op(input logic [N-1:0] a, input logic [N-1:0] b,
                    input logic m, input logic [N:0] es,
                    input logic eo, input string nm);
    int n;
    int nb;
    issue(a, b, m);
    wait_done(n, nb);
    chk({nm, "_lat"}, 32'(n), 32'd5);
    chk({nm, "_busy"}, 32'(nb), 32'd4);
    chk({nm, "_S"}, 32'(S), 32'(es));
    chk({nm, "_ovf"}, 32'(ovf), 32'(eo));
    chk({nm, "_model"}, 32'(m_s), 32'(es));
  endtask

  initial begin
    int n;
    int nb;
    int pulses;
    rst = 1'b1; start = 1'b0; mode = 1'b0; A = '0; B = '0;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_S", 32'(S), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    op(8'h05, 8'h02, 1'b0, 9'h003, 1'b0, "sub");
    op(8'h05, 8'h0A, 1'b0, 9'h1FB, 1'b0, "borrow");
    op(8'h80, 8'h01, 1'b0, 9'h07F, 1'b1, "sub_ovf");
    op(8'hFF, 8'h01, 1'b1, 9'h100, 1'b0, "add_cy");
    op(8'h7F, 8'h01, 1'b1, 9'h080, 1'b1, "add_ovf");

    // Start while busy is ignored
    issue(8'h05, 8'h02, 1'b0);
    @(posedge clk); #1;
    A = 8'h00; B = 8'hAA; mode = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      if (done) pulses++;
      @(posedge clk); #1;
    end
    chk("busy_start_pulses", 32'(pulses), 32'd1);
    chk("busy_start_S", 32'(S), 32'h003);

    // Back-to-back accept in the DONE cycle
    op(8'h20, 8'h01, 1'b1, 9'h021, 1'b0, "b2b_first");
    A = 8'h0F; B = 8'h06; mode = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_held", 32'(S), 32'h021);
    wait_done(n, nb);
    chk("b2b_lat", 32'(n), 32'd5);
    chk("b2b_S", 32'(S), 32'h009);

    // Reset in the middle of an operation
    issue(8'h55, 8'h22, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_S", 32'(S), 32'd0);
    chk("abort_ovf", 32'(ovf), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      if (done) pulses++;
      @(posedge clk); #1;
    end
    chk("abort_nodone", 32'(pulses), 32'd0);
    op(8'h10, 8'h20, 1'b1, 9'h030, 1'b0, "after_rst");

    // Random operands checked by the model every cycle
    for (int i = 0; i < 1000; i++) begin
      issue(8'($urandom), 8'($urandom), 1'($urandom));
      wait_done(n, nb);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
